alu_result_checker: RTL

- Self-checking consumer at the output end of the 7-bit ALU path. The controller issues A/B/OP into ALU_7bit; this block receives the same operands plus the ALU's result and ZF.
- Recomputes the golden result, compares, and counts passes and fails over a run of NUM_VECTORS samples.
- Captures the first failing vector and reports the final verdict.
- Sits beside ALU_7bit in the top level, in place of the bare flag_gt_zero observation.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_result_checker_golden.sv | 17 +
 rtl/alu_result_checker.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 7-bit ALU result checker.
package alu_pkg;

    localparam int DATA_W = 7;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              op;
        logic [DATA_W-1:0] result;
    } alu_vec_t;

    localparam int VEC_W = $bits(alu_vec_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_result_checker_golden.sv
// Reference model of the ALU: (a, b, op) -> expected result and zero flag.
module alu_golden_model
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              op,
    output logic [DATA_W-1:0] golden,
    output logic              golden_zf
);

    always_comb begin
        golden = (op == OP_SUB) ? (a - b) : (a + b);
        golden_zf = (golden == '0);
    end

endmodule

// File: rtl/alu_result_checker.sv
// Self-checking consumer for the ALU path: counts pass/fail over a run.
// Optional failure-log FIFO enabled by defining ALU_CHECK_FAIL_LOG_EN.
//
// state | meaning
// IDLE  | waiting for start, nothing accepted
// RUN   | accepting samples until NUM_VECTORS taken
// DRAIN | last accepted sample is being compared
// DONE  | verdict valid; start begins a new run
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int NUM_VECTORS = 32,
    parameter int CNT_W       = 8,
    parameter int LOG_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              OP,
    input  logic [DATA_W-1:0] result,
    input  logic              ZF,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [VEC_W-1:0]  first_fail,
    input  logic              log_rd,
    output logic              log_empty,
    output logic [VEC_W-1:0]  log_data
);

    localparam logic [CNT_W-1:0] NUM_V   = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] LAST_V  = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic              s1_valid_q, s1_valid_d;
    alu_vec_t          s1_vec_q, s1_vec_d;
    logic              s1_zf_q, s1_zf_d;
    alu_vec_t          first_fail_q, first_fail_d;

    logic              accept;
    logic              run_start;
    logic              mismatch;
    logic [DATA_W-1:0] golden;
    logic              golden_zf;

    assign in_ready  = (state_q == RUN) && (acc_cnt_q < NUM_V);
    assign accept    = in_valid && in_ready;
    assign run_start = start && ((state_q == IDLE) || (state_q == DONE));

    alu_golden_model u_golden (
        .a         (s1_vec_q.a),
        .b         (s1_vec_q.b),
        .op        (s1_vec_q.op),
        .golden    (golden),
        .golden_zf (golden_zf)
    );

    assign mismatch = s1_valid_q &&
                      ((s1_vec_q.result != golden) || (s1_zf_q != golden_zf));

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && (acc_cnt_q == LAST_V)) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DRAIN);
        done = (state_q == DONE);
        pass = done && (fail_cnt_q == '0);
    end

    always_comb begin
        acc_cnt_d    = acc_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        s1_valid_d   = accept;
        s1_vec_d     = s1_vec_q;
        s1_zf_d      = s1_zf_q;
        first_fail_d = first_fail_q;

        if (accept) begin
            s1_vec_d  = '{a: A, b: B, op: OP, result: result};
            s1_zf_d   = ZF;
            acc_cnt_d = acc_cnt_q + 1'b1;
        end

        // fail_cnt still zero means this is the first mismatch of the run
        if (s1_valid_q) begin
            if (mismatch) begin
                if (fail_cnt_q == '0) first_fail_d = s1_vec_q;
                if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
            end else if (pass_cnt_q != CNT_MAX) begin
                pass_cnt_d = pass_cnt_q + 1'b1;
            end
        end

        if (run_start) begin
            acc_cnt_d    = '0;
            pass_cnt_d   = '0;
            fail_cnt_d   = '0;
            s1_valid_d   = 1'b0;
            first_fail_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_cnt_q    <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_vec_q     <= '0;
            s1_zf_q      <= 1'b0;
            first_fail_q <= '0;
        end else begin
            acc_cnt_q    <= acc_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_vec_q     <= s1_vec_d;
            s1_zf_q      <= s1_zf_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign first_fail = first_fail_q;

`ifdef ALU_CHECK_FAIL_LOG_EN
    // Pointers carry one extra wrap bit to tell full from empty
    localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    alu_vec_t        log_mem_q [LOG_DEPTH];
    alu_vec_t        log_mem_d [LOG_DEPTH];
    logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;
    logic            log_full;
    logic            log_pop;
    logic            log_push;

    assign log_empty = (wr_ptr_q == rd_ptr_q);
    assign log_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign log_pop   = log_rd && !log_empty;
    assign log_push  = mismatch && (!log_full || log_pop);
    assign log_data  = log_empty ? '0 : log_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        log_mem_d = log_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (log_push) begin
            log_mem_d[wr_ptr_q[PTR_W-1:0]] = s1_vec_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (log_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (run_start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        log_mem_q <= log_mem_d;
    end
`else
    logic unused_log;
    assign unused_log = log_rd ^ (LOG_DEPTH == 0);
    assign log_empty  = 1'b1;
    assign log_data   = '0;
`endif

endmodule
